// File: rtl/cmi_recv_packet_p.sv
// CMI packet receiver: deframes 6-bit-payload bytes into header + N_WORDS words, checks CRC6,
// and presents packets through a one-deep valid/ready holding register with fault reporting.
module cmi_recv_packet_p #(
  parameter int         HEAD_W      = 8,
  parameter int         WORD_W      = 16,
  parameter int         N_WORDS     = 4,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [5:0] CRC_POLY    = 6'h03
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_rx_ena,
  input  logic [7:0]                  i_rx_data,
  output logic                        o_pkt_valid,
  input  logic                        i_pkt_ready,
  output logic [HEAD_W-1:0]           o_pkt_head,
  output logic [N_WORDS*WORD_W-1:0]   o_pkt_data,
  output logic                        o_pkt_fault,
  output logic [2:0]                  o_fault_code,
  output logic                        o_pkt_drop,
  output logic                        o_marker_st,
  output logic [1:0]                  o_marker_type,
  output logic [15:0]                 o_err_cnt
);

  localparam int PBITS  = HEAD_W + N_WORDS * WORD_W;
  localparam int PBYTES = (PBITS + 5) / 6;
  localparam int BUF_W  = PBYTES * 6;
  localparam int CNT_W  = $clog2(PBYTES + 1);
  localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PBYTES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [5:0]       MARKER   = 6'b101101;

  localparam logic [2:0] CODE_MARKER  = 3'd1;
  localparam logic [2:0] CODE_TAG     = 3'd2;
  localparam logic [2:0] CODE_CRC     = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CRC} state_t;

  // Bit-serial CRC6 over a whole received byte, bit 0 first.
  function automatic logic [5:0] crc6_byte(input logic [5:0] crc_in, input logic [7:0] d);
    logic [5:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[5] ^ d[i];
      c  = {c[4:0], 1'b0} ^ (fb ? CRC_POLY : 6'd0);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                     r_state, w_state_nxt;
  logic [5:0]                 r_crc, w_crc_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [TMR_W-1:0]           r_timer;
  logic [BUF_W-1:0]           r_buf;

  logic                       r_valid;
  logic [HEAD_W-1:0]          r_head;
  logic [N_WORDS*WORD_W-1:0]  r_data;
  logic                       r_fault, r_drop, r_mark;
  logic [2:0]                 r_code;
  logic [1:0]                 r_mtype;
  logic [15:0]                r_err;

  logic       w_marker, w_shift, w_abort, w_good, w_to_hit;
  logic       w_accept, w_load, w_drop;
  logic [1:0] w_tag;
  logic [2:0] w_code;

  assign w_marker  = i_rx_ena && (i_rx_data[5:0] == MARKER);
  assign w_tag     = i_rx_data[1:0];
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_to_hit  = (TIMEOUT_CYC != 0) && (r_state != S_IDLE) && (r_timer == TMR_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_cnt_nxt   = r_cnt;
    w_shift     = 1'b0;
    w_abort     = 1'b0;
    w_good      = 1'b0;
    w_code      = CODE_MARKER;
    if (w_marker) begin
      if (r_state != S_IDLE) begin
        w_abort = 1'b1;
        w_code  = CODE_MARKER;
      end
    end else if (i_rx_ena) begin
      case (r_state)
        S_IDLE: begin
          if (w_tag == 2'b00) begin
            w_shift     = 1'b1;
            w_crc_nxt   = crc6_byte(6'd0, i_rx_data);
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = (PBYTES == 1) ? S_CRC : S_RECV;
          end
        end
        S_RECV: begin
          if (w_tag == 2'b10) begin
            w_shift   = 1'b1;
            w_crc_nxt = crc6_byte(r_crc, i_rx_data);
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == LAST_CNT) w_state_nxt = S_CRC;
          end else begin
            w_abort = 1'b1;
            w_code  = CODE_TAG;
          end
        end
        S_CRC: begin
          if (w_tag != 2'b11) begin
            w_abort = 1'b1;
            w_code  = CODE_TAG;
          end else if (i_rx_data[7:2] != r_crc) begin
            w_abort = 1'b1;
            w_code  = CODE_CRC;
          end else begin
            w_good      = 1'b1;
            w_state_nxt = S_IDLE;
            w_crc_nxt   = 6'd0;
            w_cnt_nxt   = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_to_hit) begin
      w_abort = 1'b1;
      w_code  = CODE_TIMEOUT;
    end
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_crc_nxt   = 6'd0;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc   <= 6'd0;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      r_crc <= w_crc_nxt;
      r_cnt <= w_cnt_nxt;
      if (i_rx_ena || (r_state == S_IDLE) || w_abort) r_timer <= '0;
      else                                            r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Payload shifts in from the top so byte j lands at bits [j*6 +: 6] once the frame is complete.
  generate
    if (PBYTES == 1) begin : g_buf_one
      always_ff @(posedge i_clk) begin
        if (w_shift) r_buf <= i_rx_data[7:2];
      end
    end else begin : g_buf_shift
      always_ff @(posedge i_clk) begin
        if (w_shift) r_buf <= {i_rx_data[7:2], r_buf[BUF_W-1:6]};
      end
    end
    if (BUF_W > PBITS) begin : g_pad
      logic w_pad_unused;
      assign w_pad_unused = ^r_buf[BUF_W-1:PBITS];
    end
  endgenerate

  assign w_accept = r_valid && i_pkt_ready;
  assign w_load   = w_good && (!r_valid || w_accept);
  assign w_drop   = w_good && !w_load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_head  <= '0;
      r_data  <= '0;
      r_fault <= 1'b0;
      r_drop  <= 1'b0;
      r_mark  <= 1'b0;
      r_code  <= 3'd0;
      r_mtype <= 2'd0;
      r_err   <= 16'd0;
    end else begin
      r_fault <= w_abort;
      r_drop  <= w_drop;
      r_mark  <= w_marker;
      if (w_marker) r_mtype <= i_rx_data[7:6];
      if (w_abort)  r_code  <= w_code;
      // Fault and drop are mutually exclusive, so one increment covers both.
      if (w_abort || w_drop) r_err <= sat_inc16(r_err);
      if (w_load) begin
        r_valid <= 1'b1;
        r_head  <= r_buf[HEAD_W-1:0];
        r_data  <= r_buf[HEAD_W +: N_WORDS*WORD_W];
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_pkt_valid   = r_valid;
  assign o_pkt_head    = r_head;
  assign o_pkt_data    = r_data;
  assign o_pkt_fault   = r_fault;
  assign o_fault_code  = r_code;
  assign o_pkt_drop    = r_drop;
  assign o_marker_st   = r_mark;
  assign o_marker_type = r_mtype;
  assign o_err_cnt     = r_err;

endmodule

// File: tb/tb_cmi_recv_packet_p.sv
// Directed bench for cmi_recv_packet_p: default-geometry receiver with a short timeout,
// plus a small 4/12x2 geometry receiver.
module tb_cmi_recv_packet_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_ena, a_ready, b_ena, b_ready;
  logic [7:0]  a_data, b_data;

  logic        a_valid, a_fault, a_drop, a_mark;
  logic [7:0]  a_head;
  logic [63:0] a_pdata;
  logic [2:0]  a_code;
  logic [1:0]  a_mtype;
  logic [15:0] a_err;

  logic        b_valid, b_fault, b_drop, b_mark;
  logic [3:0]  b_head;
  logic [23:0] b_pdata;
  logic [2:0]  b_code;
  logic [1:0]  b_mtype;
  logic [15:0] b_err;

  int n_checks = 0;
  int n_errs   = 0;
  int a_fault_seen = 0;

  logic [7:0] fa [13];
  logic [7:0] fb [6];

  cmi_recv_packet_p #(.HEAD_W(8), .WORD_W(16), .N_WORDS(4), .TIMEOUT_CYC(50)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_ena(a_ena), .i_rx_data(a_data),
    .o_pkt_valid(a_valid), .i_pkt_ready(a_ready), .o_pkt_head(a_head), .o_pkt_data(a_pdata),
    .o_pkt_fault(a_fault), .o_fault_code(a_code), .o_pkt_drop(a_drop),
    .o_marker_st(a_mark), .o_marker_type(a_mtype), .o_err_cnt(a_err)
  );

  cmi_recv_packet_p #(.HEAD_W(4), .WORD_W(12), .N_WORDS(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_ena(b_ena), .i_rx_data(b_data),
    .o_pkt_valid(b_valid), .i_pkt_ready(b_ready), .o_pkt_head(b_head), .o_pkt_data(b_pdata),
    .o_pkt_fault(b_fault), .o_fault_code(b_code), .o_pkt_drop(b_drop),
    .o_marker_st(b_mark), .o_marker_type(b_mtype), .o_err_cnt(b_err)
  );

  always @(negedge clk) if (a_fault === 1'b1) a_fault_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] m_crc(input logic [5:0] c_in, input logic [7:0] d);
    logic [5:0] c;
    logic       f;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      f = c[5] ^ d[i];
      c = {c[4:0], 1'b0};
      if (f) c = c ^ 6'h03;
    end
    return c;
  endfunction

  task automatic build_a(input logic [7:0] h, input logic [15:0] w0, w1, w2, w3);
    logic [71:0] bits;
    logic [5:0]  c;
    bits = {w3, w2, w1, w0, h};
    c = 6'd0;
    for (int j = 0; j < 12; j++) begin
      fa[j] = {bits[j*6 +: 6], (j == 0) ? 2'b00 : 2'b10};
      c = m_crc(c, fa[j]);
    end
    fa[12] = {c, 2'b11};
  endtask

  task automatic build_b(input logic [3:0] h, input logic [11:0] w0, w1);
    logic [29:0] bits;
    logic [5:0]  c;
    bits = {2'b00, w1, w0, h};
    c = 6'd0;
    for (int j = 0; j < 5; j++) begin
      fb[j] = {bits[j*6 +: 6], (j == 0) ? 2'b00 : 2'b10};
      c = m_crc(c, fb[j]);
    end
    fb[5] = {c, 2'b11};
  endtask

  task automatic send_a(input logic [7:0] v);
    a_data = v;
    a_ena  = 1'b1;
    @(negedge clk);
    a_ena  = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] v);
    b_data = v;
    b_ena  = 1'b1;
    @(negedge clk);
    b_ena  = 1'b0;
  endtask

  task automatic send_a_range(input int lo, input int hi);
    for (int j = lo; j <= hi; j++) send_a(fa[j]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; a_ena = 1'b0; b_ena = 1'b0; a_data = 8'h00; b_data = 8'h00;
    a_ready = 1'b1; b_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", a_valid, 0);
    chk("rst_head", a_head, 0);
    chk("rst_data", a_pdata, 0);
    chk("rst_code", a_code, 0);
    chk("rst_err", a_err, 0);
    chk("rst_mtype", a_mtype, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame, consumer always ready
    build_a(8'hA5, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    send_a_range(0, 12);
    chk("t1_valid", a_valid, 1);
    chk("t1_head", a_head, 8'hA5);
    chk("t1_data", a_pdata, 64'hDEF0_9ABC_5678_1234);
    @(negedge clk);
    chk("t1_valid_clr", a_valid, 0);
    chk("t1_no_fault", a_fault_seen, 0);

    // CRC byte corrupted
    do_reset();
    build_a(8'hA5, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    fa[12] = fa[12] ^ 8'h10;
    send_a_range(0, 12);
    chk("t2_fault", a_fault, 1);
    chk("t2_code", a_code, 3);
    chk("t2_err", a_err, 1);
    chk("t2_valid", a_valid, 0);
    @(negedge clk);
    chk("t2_fault_pulse", a_fault, 0);

    // Marker mid-packet, then a clean frame
    do_reset();
    build_a(8'hA5, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    send_a_range(0, 5);
    send_a(8'hED);
    chk("t3_mark", a_mark, 1);
    chk("t3_mtype", a_mtype, 3);
    chk("t3_fault", a_fault, 1);
    chk("t3_code", a_code, 1);
    chk("t3_err", a_err, 1);
    send_a_range(0, 12);
    chk("t3_valid", a_valid, 1);
    chk("t3_head", a_head, 8'hA5);
    chk("t3_data", a_pdata, 64'hDEF0_9ABC_5678_1234);
    chk("t3_code_held", a_code, 1);

    // Back-pressure: hold, drop, then load on the accepting cycle
    do_reset();
    a_ready = 1'b0;
    build_a(8'hA5, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    send_a_range(0, 12);
    chk("t4_valid1", a_valid, 1);
    chk("t4_head1", a_head, 8'hA5);
    build_a(8'h3C, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    send_a_range(0, 12);
    chk("t4_drop", a_drop, 1);
    chk("t4_err", a_err, 1);
    chk("t4_hold_valid", a_valid, 1);
    chk("t4_hold_head", a_head, 8'hA5);
    chk("t4_hold_data", a_pdata, 64'hDEF0_9ABC_5678_1234);
    build_a(8'h5A, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
    send_a_range(0, 11);
    a_ready = 1'b1;
    send_a(fa[12]);
    chk("t4_no_drop", a_drop, 0);
    chk("t4_valid3", a_valid, 1);
    chk("t4_head3", a_head, 8'h5A);
    chk("t4_data3", a_pdata, 64'hFF00_00FF_F0F0_0F0F);
    chk("t4_err_same", a_err, 1);
    @(negedge clk);
    chk("t4_valid_clr", a_valid, 0);

    // Inter-byte timeout
    do_reset();
    build_a(8'hA5, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    send_a_range(0, 3);
    repeat (49) @(negedge clk);
    chk("t5_no_fault_49", a_fault, 0);
    @(negedge clk);
    chk("t5_fault_50", a_fault, 1);
    chk("t5_code", a_code, 4);
    chk("t5_err", a_err, 1);
    send_a_range(0, 3);
    repeat (49) @(negedge clk);
    send_a_range(4, 12);
    chk("t5_stall49_valid", a_valid, 1);
    chk("t5_stall49_head", a_head, 8'hA5);
    chk("t5_stall49_err", a_err, 1);

    // Small geometry and mid-frame reset
    build_b(4'h9, 12'hABC, 12'h123);
    for (int j = 0; j < 6; j++) send_b(fb[j]);
    chk("t6_valid", b_valid, 1);
    chk("t6_head", b_head, 4'h9);
    chk("t6_data", b_pdata, 24'h123ABC);
    build_b(4'h6, 12'h456, 12'h789);
    for (int j = 0; j < 3; j++) send_b(fb[j]);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", b_valid, 0);
    chk("t6_rst_head", b_head, 0);
    chk("t6_rst_data", b_pdata, 0);
    chk("t6_rst_err", b_err, 0);
    chk("t6_rst_code", b_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 6; j++) send_b(fb[j]);
    chk("t6_after_valid", b_valid, 1);
    chk("t6_after_head", b_head, 4'h6);
    chk("t6_after_data", b_pdata, 24'h789456);
    chk("t6_after_err", b_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
